// File: rtl/pipe_pkg.sv
// Shared types and default payload widths for the handshaked pipeline stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int OCC_W = 2;

  // Default payload widths for each pipeline boundary
  localparam int IF_ID_DATA_W   = 64;
  localparam int IF_ID_CTRL_W   = 4;
  localparam int ID_EX_DATA_W   = 160;
  localparam int ID_EX_CTRL_W   = 12;
  localparam int EX_MEM_DATA_W  = 104;
  localparam int EX_MEM_CTRL_W  = 8;
  localparam int MEM_WR_DATA_W  = 72;
  localparam int MEM_WR_CTRL_W  = 4;

endpackage

// File: rtl/pipe_entry.sv
// One held pipeline entry: valid bit plus datapath and control payload registers.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              pop,
  input  logic [DATA_W-1:0] d_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Clear kills the entry and its control; data is left as-is since it is never observed.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      ctrl  <= d_ctrl;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) valid/ready pipeline stage with flush, bubble control zeroing,
// occupancy reporting and a saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W              = 64,
  parameter int CTRL_W              = 8,
  parameter int ZERO_CTRL_ON_BUBBLE = 1,
  parameter int STALL_CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [OCC_W-1:0]       occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  pipe_state_t       state_p0, state_nxt;
  logic              main_valid_p0, skid_valid_p0;
  logic [DATA_W-1:0] main_data_p0, skid_data_p0, main_d_data;
  logic [CTRL_W-1:0] main_ctrl_p0, skid_ctrl_p0, main_d_ctrl;
  logic              in_fire, out_fire;
  logic              main_load, main_pop, skid_load, skid_pop;

  // in_ready comes straight off the skid valid flop, so no combinational ready path exists.
  assign in_ready  = ~skid_valid_p0;
  assign out_valid = main_valid_p0;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid_p0 & out_ready;

  assign main_d_data = (state_p0 == FULL) ? skid_data_p0 : in_data;
  assign main_d_ctrl = (state_p0 == FULL) ? skid_ctrl_p0 : in_ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_p0 <= EMPTY;
    else       state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    main_load = 1'b0;
    main_pop  = 1'b0;
    skid_load = 1'b0;
    skid_pop  = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            main_pop  = 1'b1;
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_load = 1'b1;
            skid_pop  = 1'b1;
            state_nxt = BUSY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .load   (main_load),
    .pop    (main_pop),
    .d_data (main_d_data),
    .d_ctrl (main_d_ctrl),
    .valid  (main_valid_p0),
    .data   (main_data_p0),
    .ctrl   (main_ctrl_p0)
  );

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .load   (skid_load),
    .pop    (skid_pop),
    .d_data (in_data),
    .d_ctrl (in_ctrl),
    .valid  (skid_valid_p0),
    .data   (skid_data_p0),
    .ctrl   (skid_ctrl_p0)
  );

  assign out_data  = main_data_p0;
  assign out_ctrl  = (ZERO_CTRL_ON_BUBBLE != 0 && !main_valid_p0) ? '0 : main_ctrl_p0;
  assign occupancy = {1'b0, main_valid_p0} + {1'b0, skid_valid_p0};

  // Stall counter is only reset, never flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_valid_p0 && !out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed table-driven bench for pipe_stage_skid plus hand sequences for stall saturation.
module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam int CW = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data = '0, out_data;
  logic [CW-1:0] in_ctrl = '0, out_ctrl;
  logic [1:0]    occupancy;
  logic [SW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  pipe_stage_skid #(
    .DATA_W(DW), .CTRL_W(CW), .ZERO_CTRL_ON_BUBBLE(1), .STALL_CNT_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, fl, iv;
    logic [DW-1:0] id;
    logic [CW-1:0] ic;
    logic          ordy;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic [CW-1:0] e_oc;
    logic [1:0]    e_occ;
    logic          e_irdy;
    logic [SW-1:0] e_sc;
  } vec_t;

  vec_t vecs[$];

  // Upstream must hold a refused entry stable until accepted (flush/reset excepted).
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data;
  logic [CW-1:0] hold_ctrl;
  always @(posedge clk) begin
    if (hold_pend && !reset && !flush) begin
      checks++;
      if (!(in_valid && in_data == hold_data && in_ctrl == hold_ctrl)) begin
        failures++;
        $display("FAIL protocol_hold: in_valid=%0b in_data=%h in_ctrl=%h, required 1 %h %h",
                 in_valid, in_data, in_ctrl, hold_data, hold_ctrl);
      end
    end
    hold_pend <= in_valid && !in_ready && !reset && !flush;
    hold_data <= in_data;
    hold_ctrl <= in_ctrl;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, f, iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input logic ordy, input logic eov, input logic [DW-1:0] eod,
                     input logic [CW-1:0] eoc, input logic [1:0] eocc, input logic eirdy,
                     input logic [SW-1:0] esc);
    vec_t v;
    v.rst = r; v.fl = f; v.iv = iv; v.id = d; v.ic = c; v.ordy = ordy;
    v.e_ov = eov; v.e_od = eod; v.e_oc = eoc; v.e_occ = eocc; v.e_irdy = eirdy; v.e_sc = esc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, f, iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy);
    reset = r; flush = f; in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   rst fl iv data    ctrl   ordy | ov  data     ctrl  occ irdy sc
    add(1, 0, 0, 16'h0,   8'h0,  1,     0, 16'h0,   8'h0,  0, 1, 0); // reset
    add(0, 0, 1, 16'h1,   8'h11, 1,     1, 16'h1,   8'h11, 1, 1, 0); // stream 1..4
    add(0, 0, 1, 16'h2,   8'h12, 1,     1, 16'h2,   8'h12, 1, 1, 0);
    add(0, 0, 1, 16'h3,   8'h13, 1,     1, 16'h3,   8'h13, 1, 1, 0);
    add(0, 0, 1, 16'h4,   8'h14, 1,     1, 16'h4,   8'h14, 1, 1, 0);
    add(0, 0, 0, 16'h0,   8'h0,  1,     0, 16'h4,   8'h0,  0, 1, 0); // drain, bubble
    add(0, 0, 1, 16'hAA,  8'hA1, 0,     1, 16'hAA,  8'hA1, 1, 1, 0); // backpressure fill
    add(0, 0, 1, 16'hBB,  8'hB1, 0,     1, 16'hAA,  8'hA1, 2, 0, 1);
    add(0, 0, 0, 16'h0,   8'h0,  1,     1, 16'hBB,  8'hB1, 1, 1, 1);
    add(0, 0, 0, 16'h0,   8'h0,  1,     0, 16'hBB,  8'h0,  0, 1, 1);
    add(0, 0, 1, 16'h10,  8'h5A, 0,     1, 16'h10,  8'h5A, 1, 1, 1); // fill for flush
    add(0, 0, 1, 16'h20,  8'h5A, 0,     1, 16'h10,  8'h5A, 2, 0, 2);
    add(0, 1, 1, 16'h30,  8'h77, 0,     0, 16'h10,  8'h0,  0, 1, 3); // flush while FULL
    add(0, 0, 0, 16'h0,   8'h0,  1,     0, 16'h10,  8'h0,  0, 1, 3);
    add(0, 0, 1, 16'hC,   8'hC1, 1,     1, 16'hC,   8'hC1, 1, 1, 3); // simultaneous in/out
    add(0, 0, 1, 16'hD,   8'hD1, 1,     1, 16'hD,   8'hD1, 1, 1, 3);
    add(0, 0, 0, 16'h0,   8'h0,  1,     0, 16'hD,   8'h0,  0, 1, 3);
    add(0, 0, 1, 16'hE1,  8'hE1, 0,     1, 16'hE1,  8'hE1, 1, 1, 3); // reset mid-operation
    add(0, 0, 1, 16'hE2,  8'hE2, 0,     1, 16'hE1,  8'hE1, 2, 0, 4);
    add(1, 1, 1, 16'hE3,  8'hE3, 0,     0, 16'h0,   8'h0,  0, 1, 0);
    add(0, 0, 0, 16'h0,   8'h0,  1,     0, 16'h0,   8'h0,  0, 1, 0);
    add(0, 0, 0, 16'h0,   8'h0,  1,     0, 16'h0,   8'h0,  0, 1, 0);

    #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ic, vecs[i].ordy);
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vecs[i].e_od));
      chk($sformatf("v%0d_out_ctrl", i),  32'(out_ctrl),  32'(vecs[i].e_oc));
      chk($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
      chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_irdy));
      chk($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_sc));
    end

    // Stall counter saturation: one held entry, 10 stalled cycles
    drive(1, 0, 0, 16'h0, 8'h0, 0);
    drive(0, 0, 1, 16'h5555, 8'h3C, 0);
    chk("sat_load_valid", 32'(out_valid), 32'd1);
    chk("sat_start_cnt", 32'(stall_cnt), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      drive(0, 0, 0, 16'h0, 8'h0, 0);
      chk($sformatf("sat_cnt_%0d", k), 32'(stall_cnt), 32'((k < 7) ? k : 7));
      chk($sformatf("sat_data_%0d", k), 32'(out_data), 32'h5555);
    end

    // Flush keeps the saturated count; an out_fire during flush leaves nothing behind
    drive(0, 1, 0, 16'h0, 8'h0, 0);
    chk("flush_keeps_cnt", 32'(stall_cnt), 32'd7);
    chk("flush_bubble_ctrl", 32'(out_ctrl), 32'd0);
    drive(0, 0, 1, 16'h66, 8'h61, 1);
    drive(0, 1, 1, 16'h77, 8'h71, 1);
    chk("flush_outfire_valid", 32'(out_valid), 32'd0);
    chk("flush_outfire_occ", 32'(occupancy), 32'd0);
    drive(0, 0, 0, 16'h0, 8'h0, 1);
    chk("flush_drop_valid", 32'(out_valid), 32'd0);
    chk("flush_drop_data", 32'(out_data), 32'h66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, handshaked successor to the fixed-width stage registers between IF/ID/EX/MEM/WR.
- Carries a generic datapath payload and a control payload through a two-entry stage: a main register plus a skid register.
- Uses valid/ready flow control, so stalls propagate without combinational ready paths.
- Adds flush (bubble insertion), bubble zeroing of control, occupancy reporting and a saturating stall counter for performance debug.

Parameters:
- DATA_W, 64, width of datapath payload (PC, operands, immediates concatenated by the instantiating stage).
- CTRL_W, 8, width of control payload (RegWrite, MemWrite, etc.).
- ZERO_CTRL_ON_BUBBLE, 1, when 1, out_ctrl is forced to 0 whenever out_valid=0.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  kill all held entries (branch mispredict / exception).
- in_valid  in  1  upstream presents a valid entry.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main entry datapath payload.
- out_ctrl  out  CTRL_W  main entry control payload (zeroed on bubble if ZERO_CTRL_ON_BUBBLE).
- occupancy  out  2  number of held entries, 0..2.
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (synchronous, active-high): the edge with reset=1 sets state EMPTY.
  - Output values after that edge: out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0, in_ready=1.
  - Reset has priority over flush and all handshakes, including mid-operation.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- FSM states: EMPTY (occupancy 0), BUSY (main valid, occupancy 1), FULL (main+skid valid, occupancy 2).
  - EMPTY: in_fire -> BUSY, main<=in. Otherwise stay.
  - BUSY: in_fire & out_fire -> BUSY, main<=in. in_fire only -> FULL, skid<=in. out_fire only -> EMPTY. Neither -> hold.
  - FULL: in_ready=0, so in_fire is impossible. out_fire -> BUSY, main<=skid. Otherwise hold.
- Latency: 1 cycle from in_fire to out_valid when EMPTY, or BUSY with simultaneous out_fire. Entries leave strictly in FIFO order.
- in_ready is a registered output. It has no combinational dependence on out_ready, which breaks the ready chain between stages.
- Flush (reset=0, flush=1): next state EMPTY.
  - Main and skid valid bits cleared; held control payloads cleared to 0. Data contents are don't-care but must not be observed (out_ctrl=0 when ZERO_CTRL_ON_BUBBLE=1).
  - Any in_fire in the flush cycle is dropped.
  - An out_fire in the flush cycle completes normally downstream.
  - stall_cnt is not cleared by flush.
- Bubble: when out_valid=0 and ZERO_CTRL_ON_BUBBLE=1, out_ctrl=0 regardless of held contents. out_data holds its last value.
- Data/ctrl registers load only on their load condition. There is no spurious capture while stalled.
- stall_cnt increments by 1 on every cycle with out_valid & !out_ready. It saturates at 2^STALL_CNT_W-1 and does not wrap.
- Protocol: once in_valid=1 with in_ready=0, upstream holds in_valid/in_data/in_ctrl stable. A bench assertion checks this.

Decomposition:
- Shared package pipe_pkg:
  - Typedef pipe_state_t enum {EMPTY, BUSY, FULL}.
  - Constant OCC_W=2.
  - Default width constants for each pipeline boundary (IF_ID, ID_EX, EX_MEM, MEM_WR payload widths).
- One sub-module, pipe_entry: valid bit + DATA_W + CTRL_W registers with synchronous reset, load and clear inputs. It is instantiated twice (main, skid).

Test Plan:
- Reset then stream: out_ready=1, in_valid=1 with in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later each; occupancy=1 steady; in_ready=1 throughout; stall_cnt=0.
- Backpressure fill: out_ready=0, push A=0xAA then B=0xBB -> occupancy 1 then 2; in_ready=0 the cycle after B; out_data=0xAA held; then release out_ready=1 -> out_data 0xAA, 0xBB in order, occupancy 2->1->0.
- Flush while FULL: state FULL (ctrl=0x5A in both entries), flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; the flushed-cycle input never appears.
- Simultaneous in/out in BUSY: main=C, in_valid=1, out_ready=1 -> next cycle out_data=new entry, occupancy stays 1, skid unused.
- Stall counter saturation: STALL_CNT_W=3, hold out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=1..7 then holds 7.
- Reset mid-operation: FULL state plus reset=1 with flush=1 and in_valid=1 -> all outputs at reset values next cycle; no entry emerges afterwards.
